// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: three-port round-robin arbiter and transaction sequencer for the external memory bus
module mem_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_read_request,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_response,
  output logic [DATA_WIDTH-1:0] p0_read_data,
  input  logic                  p1_read_request,
  input  logic                  p1_write_request,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic                  p1_response,
  output logic [DATA_WIDTH-1:0] p1_read_data,
  input  logic                  p2_read_request,
  input  logic                  p2_write_request,
  input  logic [ADDR_WIDTH-1:0] p2_addr,
  input  logic [DATA_WIDTH-1:0] p2_write_data,
  output logic                  p2_response,
  output logic [DATA_WIDTH-1:0] p2_read_data,
  output logic                  bus_error,
  output logic                  memory_read_request,
  output logic                  memory_write_request,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic                  memory_response,
  input  logic [DATA_WIDTH-1:0] memory_read_data
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                r_state;
  logic [1:0]            r_last, r_grant;
  logic [15:0]           r_cnt;
  logic [2:0]            r_resp;
  logic                  r_err, r_mem_rd, r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [2:0]            w_req, w_wr;
  logic [ADDR_WIDTH-1:0] w_addr [3];
  logic [DATA_WIDTH-1:0] w_wdata [3];
  logic [1:0]            w_o1, w_o2, w_win;
  logic                  w_timeout;
  assign w_req      = {p2_read_request | p2_write_request, p1_read_request | p1_write_request, p0_read_request};
  assign w_wr       = {p2_write_request, p1_write_request, 1'b0};
  assign w_addr[0]  = p0_addr;
  assign w_addr[1]  = p1_addr;
  assign w_addr[2]  = p2_addr;
  assign w_wdata[0] = '0;
  assign w_wdata[1] = p1_write_data;
  assign w_wdata[2] = p2_write_data;
  assign w_timeout  = r_cnt == 16'(TIMEOUT_CYCLES - 1);
  // round-robin search starting just after the last winner, ending with the last winner itself
  always_comb begin
    w_o1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_o2  = (r_last == 2'd0) ? 2'd2 : r_last - 2'd1;
    w_win = w_req[w_o1] ? w_o1 : w_req[w_o2] ? w_o2 : r_last;
  end
  // transaction sequencer: grant in IDLE, hold the bus in BUSY, one-cycle completion in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 2'd2;
      r_grant  <= 2'd0;
      r_cnt    <= '0;
      r_resp   <= '0;
      r_err    <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_grant  <= w_win;
          r_last   <= w_win;
          r_addr   <= w_addr[w_win];
          r_wdata  <= w_wdata[w_win];
          r_mem_rd <= !w_wr[w_win];
          r_mem_wr <= w_wr[w_win];
          r_cnt    <= '0;
          r_state  <= BUSY;
        end
        BUSY: if (memory_response || w_timeout) begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_addr   <= '0;
          r_wdata  <= '0;
          r_rdata  <= (memory_response && r_mem_rd) ? memory_read_data : '0;
          r_err    <= !memory_response;
          r_resp   <= 3'b001 << r_grant;
          r_state  <= RESP;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        default: begin
          r_resp  <= '0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign p0_response          = r_resp[0];
  assign p1_response          = r_resp[1];
  assign p2_response          = r_resp[2];
  assign p0_read_data         = r_resp[0] ? r_rdata : '0;
  assign p1_read_data         = r_resp[1] ? r_rdata : '0;
  assign p2_read_data         = r_resp[2] ? r_rdata : '0;
  assign bus_error            = r_err;
  assign memory_read_request  = r_mem_rd;
  assign memory_write_request = r_mem_wr;
  assign memory_addr          = r_addr;
  assign memory_write_data    = r_wdata;
endmodule
